mac_relu_pool: RTL and testbench
================================

Name: mac_relu_pool

Overview:
- Downstream consumer of the multiply-accumulate stage.
- Recovers each completed dot-product sum from the MAC's free-running data_out, using a delayed copy of the new_sum strobe.
- Per sum: adds a bias, arithmetic right-shifts, applies ReLU, saturates, then max-pools POOL_SIZE consecutive results.
- Pooled outputs are buffered in a small FIFO with a valid/ready interface toward the next layer's line buffer.

Parameters:
- BW_IN, 16: width of MAC sum input, signed two's complement.
- BW_OUT, 8: width of output activation, unsigned after ReLU.
- BW_BIAS, 16: width of bias input, signed.
- R_SHIFT, 4: arithmetic right shift applied after bias add.
- SUM_LATENCY, 4: cycles from new_sum at the MAC input until the completed previous sum is stable on the MAC data_out; range 1..32.
- POOL_SIZE, 2: number of consecutive sums max-pooled into one output; range 1..8.
- LOG2_FIFO_DEPTH, 2: output FIFO holds 1<<LOG2_FIFO_DEPTH entries.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- new_sum, input, 1: the same strobe driven to the MAC's new_sum, one cycle per strobe.
- sum_in, input, BW_IN: MAC data_out.
- bias, input, BW_BIAS: signed bias, quasi-static; sampled on each capture.
- out_vld, output, 1: FIFO head valid.
- out_rdy, input, 1: downstream accept.
- out_data, output, BW_OUT: FIFO head activation.
- overflow, output, 1: sticky flag; a pooled result was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert internally) clears all state:
  - delay line, primed flag, pool counter, pool max, FIFO pointers;
  - out_vld=0, out_data=0, overflow=0.
- Strobe delay:
  - new_sum passes through a SUM_LATENCY-stage shift register; its output is cap_stb.
  - A new_sum asserted at cycle t produces cap_stb at t+SUM_LATENCY.
- Priming:
  - The first cap_stb after reset only sets primed=1 and captures nothing, because no preceding sum exists.
  - Each subsequent cap_stb captures sum_in.
- Stage 1, at the cap_stb cycle, registered:
  - s1 = sign-extended sum_in + sign-extended bias, computed at BW_IN+BW_BIAS+1 bits with no wrap.
  - s1_vld is asserted.
- Stage 2, registered:
  - sh = s1 >>> R_SHIFT (floor; see optional feature).
  - act = 0 if sh<0; (1<<BW_OUT)-1 if sh exceeds that; else sh[BW_OUT-1:0].
  - Result is a1 with a1_vld.
- Stage 3, pool:
  - On a1_vld with pool_cnt==0, pool_max=act; otherwise pool_max=max(pool_max, act).
  - pool_cnt increments and wraps at POOL_SIZE-1.
  - On the wrap, or on every a1_vld when POOL_SIZE=1, the pooled value (including the current act) is pushed.
- Latency: from capturing cap_stb to FIFO entry visible on out_vld is 3 cycles, when the FIFO was empty.
- FIFO behaviour:
  - Standard synchronous FIFO; out_data shows the head whenever out_vld=1.
  - Pop when out_vld&&out_rdy.
  - Push and pop in the same cycle while full: both succeed, with no overflow.
  - Push while full without a pop: the value is dropped, overflow is set to 1 and held until reset, and FIFO contents are unchanged.
  - out_vld and out_data stay stable while out_rdy=0.
- Back-to-back strobes (new_sum on consecutive cycles) are legal; every stage accepts one sum per cycle.
- new_sum asserted during reset is ignored; the delay line is held cleared.
- Reset mid-operation discards partial pools and FIFO contents; priming is required again.

Optional Feature:
- Macro: MAC_RELU_POOL_ROUND_EN.
- Defined: stage 2 computes sh = (s1 + (1<<(R_SHIFT-1))) >>> R_SHIFT, i.e. round half up. The add is done at one extra bit so it cannot wrap. When R_SHIFT==0 no rounding term is added.
- Undefined: sh = s1 >>> R_SHIFT, i.e. truncation toward negative infinity.

Test Plan:
- Priming: reset, then SUM_LATENCY=4, POOL_SIZE=1, bias=0, R_SHIFT=0. Strobes at cycles 10 and 20 with sum_in=37 stable at cycle 24 → exactly one output 37, visible on out_vld at cycle 27; nothing is produced for the cycle-14 capture.
- ReLU/saturation: POOL_SIZE=1, R_SHIFT=4, bias=0; captured sums -100, 80, 5000 → outputs 0, 5, 255.
- Bias/rounding: bias=-8, R_SHIFT=4, sum=32 → truncate 1; with MAC_RELU_POOL_ROUND_EN, sum=31 → 1 rounded versus 1 truncated, and sum=25 → 1 rounded versus 1 truncated.
- Pooling: POOL_SIZE=2; captured activations 3, 9, 7, 2, 0, 0 → outputs 9, 7, 0 in order.
- Back-pressure/overflow: out_rdy=0, depth 4, POOL_SIZE=1; six captures of 1..6 → FIFO holds 1..4 and overflow=1. Raising out_rdy drains 1, 2, 3, 4 and overflow remains 1.
- Async reset: assert rst_n=0 mid-pool with FIFO non-empty → out_vld=0, out_data=0, overflow=0 immediately. After release, the first strobe again primes only.

Source files
------------

// File: rtl/mac_relu_pool_if.sv
// Stream bundle between the MAC/strobe source, mac_relu_pool and the next layer's line buffer.
// The slave modport is the mac_relu_pool side; the master modport is the driver/consumer side.
interface mac_relu_pool_if #(
  parameter int BW_IN   = 16,
  parameter int BW_OUT  = 8,
  parameter int BW_BIAS = 16
);
  logic               new_sum;
  logic [BW_IN-1:0]   sum_in;
  logic [BW_BIAS-1:0] bias;
  logic               out_vld;
  logic               out_rdy;
  logic [BW_OUT-1:0]  out_data;
  logic               overflow;

  modport master (output new_sum, sum_in, bias, out_rdy,
                  input  out_vld, out_data, overflow);
  modport slave  (input  new_sum, sum_in, bias, out_rdy,
                  output out_vld, out_data, overflow);
endinterface

// File: rtl/mac_relu_pool.sv
// mac_relu_pool: recovers MAC sums, adds bias, shifts, ReLU/saturates, max-pools and queues them.
// Optional round-half-up in the shift stage when MAC_RELU_POOL_ROUND_EN is defined.
module mac_relu_pool #(
  parameter int BW_IN           = 16,
  parameter int BW_OUT          = 8,
  parameter int BW_BIAS         = 16,
  parameter int R_SHIFT         = 4,
  parameter int SUM_LATENCY     = 4,
  parameter int POOL_SIZE       = 2,
  parameter int LOG2_FIFO_DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  mac_relu_pool_if.slave bus
);
  localparam int W1    = BW_IN + BW_BIAS + 1;
  localparam int W2    = W1 + 1;
  localparam int CW    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int AW    = LOG2_FIFO_DEPTH;
  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam logic signed [W2-1:0] ACT_MAX = W2'((1 << BW_OUT) - 1);
`ifdef MAC_RELU_POOL_ROUND_EN
  localparam logic signed [W2-1:0] RND = W2'((1 << R_SHIFT) >> 1);
`endif

  function automatic logic signed [W2-1:0] shift_round(input logic signed [W1-1:0] s);
    logic signed [W2-1:0] x;
`ifdef MAC_RELU_POOL_ROUND_EN
    x = W2'(s) + RND;
`else
    x = W2'(s);
`endif
    return x >>> R_SHIFT;
  endfunction

  function automatic logic [BW_OUT-1:0] relu_sat(input logic signed [W2-1:0] sh);
    if (sh < 0)       return '0;
    if (sh > ACT_MAX) return '1;
    return sh[BW_OUT-1:0];
  endfunction

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Strobe delay: cap_stb marks the cycle the previous sum is stable on sum_in.
  logic [SUM_LATENCY-1:0] r_dly;
  logic                   w_cap_stb;
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= bus.new_sum;
      for (int i = 1; i < SUM_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end
  assign w_cap_stb = r_dly[SUM_LATENCY-1];

  // Stage p1: bias add at full width; the very first strobe only primes.
  logic signed [BW_IN-1:0]   w_sum;
  logic signed [BW_BIAS-1:0] w_bias;
  logic signed [W1-1:0]      r_s1_p1;
  logic                      r_primed, r_vld_p1, r_vld_p2;
  logic [BW_OUT-1:0]         r_act_p2;
  assign w_sum  = bus.sum_in;
  assign w_bias = bus.bias;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_primed <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_cap_stb && r_primed;
      r_vld_p2 <= r_vld_p1;
      if (w_cap_stb) r_primed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap_stb && r_primed) r_s1_p1 <= W1'(w_sum) + W1'(w_bias);
    // Stage p2: shift, ReLU and saturate.
    if (r_vld_p1) r_act_p2 <= relu_sat(shift_round(r_s1_p1));
  end

  // Stage p3: running max over POOL_SIZE activations, pushed on the last one.
  logic [CW-1:0]     r_pool_cnt;
  logic [BW_OUT-1:0] r_pool_max, w_pooled;
  logic              w_last, w_push;
  assign w_last   = (r_pool_cnt == CW'(POOL_SIZE - 1));
  assign w_pooled = ((r_pool_cnt == '0) || (r_act_p2 > r_pool_max)) ? r_act_p2 : r_pool_max;
  assign w_push   = r_vld_p2 && w_last;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pool_cnt <= '0;
      r_pool_max <= '0;
    end else if (r_vld_p2) begin
      r_pool_cnt <= w_last ? '0 : r_pool_cnt + 1'b1;
      r_pool_max <= w_pooled;
    end
  end

  // Output FIFO: extra pointer bit separates full from empty.
  logic [BW_OUT-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic              r_ovf, w_empty, w_full, w_pop, w_wr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.out_rdy;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_pooled;
  end

  assign bus.out_vld  = !w_empty;
  assign bus.out_data = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_mac_relu_pool.sv
// tb_mac_relu_pool: two instances (POOL_SIZE 1 and 2) share one stimulus stream and are
// compared against a behavioural model of bias/shift/ReLU/saturate/pool.
module tb_mac_relu_pool;
  localparam int L  = 4;
  localparam int RS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_relu_pool_if ifa ();
  mac_relu_pool_if ifb ();
  assign ifb.new_sum = ifa.new_sum;
  assign ifb.sum_in  = ifa.sum_in;
  assign ifb.bias    = ifa.bias;
  assign ifb.out_rdy = ifa.out_rdy;

  mac_relu_pool #(.POOL_SIZE(1)) u_dut_p1 (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mac_relu_pool #(.POOL_SIZE(2)) u_dut_p2 (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int gotA[$], gotB[$], expA[$], expB[$], m_pool[$];
  bit m_primed;
  int cur_bias;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.out_vld && ifa.out_rdy) gotA.push_back(int'(ifa.out_data));
      if (ifb.out_vld && ifb.out_rdy) gotB.push_back(int'(ifb.out_data));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int model_act(int s, int b);
    longint v, q, d;
    d = longint'(1) << RS;
    v = longint'(s) + longint'(b);
`ifdef MAC_RELU_POOL_ROUND_EN
    v = v + d / 2;
`endif
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    if (q < 0)   return 0;
    if (q > 255) return 255;
    return int'(q);
  endfunction

  function automatic void model_capture(int v);
    int a;
    if (!m_primed) begin
      m_primed = 1'b1;
    end else begin
      a = model_act(v, cur_bias);
      expA.push_back(a);
      m_pool.push_back(a);
      if (m_pool.size() == 2) begin
        expB.push_back((m_pool[0] > m_pool[1]) ? m_pool[0] : m_pool[1]);
        m_pool.delete();
      end
    end
  endfunction

  function automatic void clear_model();
    gotA.delete(); gotB.delete(); expA.delete(); expB.delete(); m_pool.delete();
    m_primed = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_bias(int b);
    cur_bias = b;
    ifa.bias = 16'(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.new_sum = 1'b0;
    ifa.out_rdy = 1'b0;
    ifa.sum_in  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    clear_model();
  endtask

  // rdy_mode: 0 leave out_rdy alone, 1 hold high, 2 random with at most two low cycles in a row
  task automatic run_stream(input int vals[$], input int step, input int rdy_mode);
    int n, last, j;
    bit lo1, lo2, r;
    n = vals.size();
    last = (n - 1) * step + L + 3;
    lo1 = 1'b0; lo2 = 1'b0;
    for (int i = 0; i <= last; i++) begin
      tick();
      ifa.new_sum = (i % step == 0) && (i / step < n);
      j = i - L;
      if (j >= 0 && j % step == 0 && j / step < n) begin
        ifa.sum_in = 16'(vals[j / step]);
        model_capture(vals[j / step]);
      end else begin
        ifa.sum_in = 16'($urandom);
      end
      if (rdy_mode == 1) ifa.out_rdy = 1'b1;
      else if (rdy_mode == 2) begin
        r = ($urandom_range(0, 3) != 0) || (lo1 && lo2);
        lo2 = lo1; lo1 = !r;
        ifa.out_rdy = r;
      end
    end
    tick();
    ifa.new_sum = 1'b0;
  endtask

  task automatic drain();
    ifa.out_rdy = 1'b1;
    repeat (30) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.new_sum = 1'b1;
    ifa.out_rdy = 1'b1;
    set_bias(0);
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (ifa.out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", ifa.out_vld); end
    n_checks++; if (ifa.out_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", ifa.out_data); end
    n_checks++; if (ifa.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ifa.overflow); end
    tick();
    rst_n = 1'b1;
    ifa.new_sum = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    n_checks++; if (ifa.out_vld !== 1'b0 || ifb.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_vld: got %b/%b expected 0/0", ifa.out_vld, ifb.out_vld);
    end
  endtask

  task automatic test_priming();
    do_reset();
    set_bias(0);
    for (int i = 0; i <= 20; i++) begin
      tick();
      ifa.new_sum = (i == 0) || (i == 10);
      ifa.sum_in  = (i == 14) ? 16'd592 : 16'($urandom);
      @(negedge clk);
      if (i == 7 || i == 16) begin
        n_checks++; if (ifa.out_vld !== 1'b0) begin n_fail++; $display("FAIL prime_early_vld c%0d: got %b expected 0", i, ifa.out_vld); end
      end
      if (i == 17) begin
        n_checks++; if (ifa.out_vld !== 1'b1) begin n_fail++; $display("FAIL prime_latency_vld: got %b expected 1", ifa.out_vld); end
        n_checks++; if (ifa.out_data !== 8'd37) begin n_fail++; $display("FAIL prime_data: got %0d expected 37", ifa.out_data); end
      end
    end
    drain();
    n_checks++; if (gotA.size() != 1) begin n_fail++; $display("FAIL prime_count: got %0d outputs expected 1", gotA.size()); end
    n_checks++; if (gotB.size() != 0) begin n_fail++; $display("FAIL prime_pool2_count: got %0d outputs expected 0", gotB.size()); end
  endtask

  task automatic test_relu_sat();
    int ex[$] = {0, 5, 255};
    do_reset();
    set_bias(0);
    run_stream({0, -100, 80, 5000}, 3, 1);
    drain();
    n_checks++; if (gotA.size() != ex.size()) begin n_fail++; $display("FAIL relu_count: got %0d expected %0d", gotA.size(), ex.size()); end
    foreach (ex[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== ex[k]) begin n_fail++; $display("FAIL relu_out%0d: got %0d expected %0d", k, gotA[k], ex[k]); end
    end
    n_checks++; if (gotB.size() != 1 || gotB[0] != 5) begin n_fail++; $display("FAIL relu_pool2: got %0d items first %0d expected 1 item 5", gotB.size(), (gotB.size() > 0) ? gotB[0] : -1); end
  endtask

  task automatic test_bias_round();
`ifdef MAC_RELU_POOL_ROUND_EN
    int ex[$] = {2, 1, 1, 0, 2};
`else
    int ex[$] = {1, 1, 1, 0, 1};
`endif
    do_reset();
    set_bias(-8);
    run_stream({0, 32, 31, 25, 0, 39}, 2, 1);
    drain();
    n_checks++; if (gotA.size() != ex.size()) begin n_fail++; $display("FAIL bias_count: got %0d expected %0d", gotA.size(), ex.size()); end
    foreach (ex[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== ex[k]) begin n_fail++; $display("FAIL bias_out%0d: got %0d expected %0d", k, gotA[k], ex[k]); end
    end
  endtask

  task automatic test_pooling();
    int exb[$] = {9, 7, 0};
    int exa[$] = {3, 9, 7, 2, 0, 0};
    do_reset();
    set_bias(0);
    run_stream({0, 48, 144, 112, 32, 0, 0}, 1, 1);
    drain();
    n_checks++; if (gotB.size() != exb.size()) begin n_fail++; $display("FAIL pool_count: got %0d expected %0d", gotB.size(), exb.size()); end
    foreach (exb[k]) if (k < gotB.size()) begin
      n_checks++; if (gotB[k] !== exb[k]) begin n_fail++; $display("FAIL pool_out%0d: got %0d expected %0d", k, gotB[k], exb[k]); end
    end
    n_checks++; if (gotA.size() != exa.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", gotA.size(), exa.size()); end
    foreach (exa[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== exa[k]) begin n_fail++; $display("FAIL b2b_out%0d: got %0d expected %0d", k, gotA[k], exa[k]); end
    end
  endtask

  task automatic test_overflow();
    int ex[$] = {1, 2, 3, 4};
    do_reset();
    set_bias(0);
    ifa.out_rdy = 1'b0;
    run_stream({0, 16, 32, 48, 64, 80, 96}, 2, 0);
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (ifa.out_vld !== 1'b1 || ifa.out_data !== 8'd1) begin n_fail++; $display("FAIL ovf_head: got vld %b data %0d expected 1/1", ifa.out_vld, ifa.out_data); end
    n_checks++; if (ifa.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ifa.overflow); end
    n_checks++; if (ifb.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pool2_flag: got %b expected 0", ifb.overflow); end
    drain();
    @(negedge clk);
    n_checks++; if (gotA.size() != ex.size()) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", gotA.size(), ex.size()); end
    foreach (ex[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== ex[k]) begin n_fail++; $display("FAIL ovf_out%0d: got %0d expected %0d", k, gotA[k], ex[k]); end
    end
    n_checks++; if (ifa.overflow !== 1'b1 || ifa.out_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: got ovf %b vld %b expected 1/0", ifa.overflow, ifa.out_vld); end
  endtask

  task automatic test_full_push_pop();
    int ex[$] = {1, 2, 3, 4, 5};
    do_reset();
    set_bias(0);
    for (int i = 0; i <= 14; i++) begin
      tick();
      ifa.new_sum = (i <= 5);
      ifa.sum_in  = (i >= 5 && i <= 9) ? 16'(16 * (i - 4)) : 16'($urandom);
      ifa.out_rdy = (i == 11);
    end
    @(negedge clk);
    n_checks++; if (ifa.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b expected 0", ifa.overflow); end
    n_checks++; if (ifa.out_data !== 8'd2) begin n_fail++; $display("FAIL fullpop_head: got %0d expected 2", ifa.out_data); end
    drain();
    n_checks++; if (gotA.size() != ex.size()) begin n_fail++; $display("FAIL fullpop_count: got %0d expected %0d", gotA.size(), ex.size()); end
    foreach (ex[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== ex[k]) begin n_fail++; $display("FAIL fullpop_out%0d: got %0d expected %0d", k, gotA[k], ex[k]); end
    end
  endtask

  task automatic test_random();
    int v[$];
    do_reset();
    for (int round = 0; round < 2; round++) begin
      set_bias(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100);
      v.delete();
      for (int k = 0; k < 31; k++)
        v.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4600)) - 200);
      if (round == 0) run_stream(v, 1, 1);
      else            run_stream(v, 3, 2);
    end
    drain();
    n_checks++; if (gotA.size() != expA.size()) begin n_fail++; $display("FAIL rand_countA: got %0d expected %0d", gotA.size(), expA.size()); end
    foreach (expA[k]) if (k < gotA.size()) begin
      n_checks++; if (gotA[k] !== expA[k]) begin n_fail++; $display("FAIL rand_A%0d: got %0d expected %0d", k, gotA[k], expA[k]); end
    end
    n_checks++; if (gotB.size() != expB.size()) begin n_fail++; $display("FAIL rand_countB: got %0d expected %0d", gotB.size(), expB.size()); end
    foreach (expB[k]) if (k < gotB.size()) begin
      n_checks++; if (gotB[k] !== expB[k]) begin n_fail++; $display("FAIL rand_B%0d: got %0d expected %0d", k, gotB[k], expB[k]); end
    end
    n_checks++; if (ifa.overflow !== 1'b0 || ifb.overflow !== 1'b0) begin n_fail++; $display("FAIL rand_ovf: got %b/%b expected 0/0", ifa.overflow, ifb.overflow); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_bias(0);
    run_stream({0, 16, 32, 48, 64, 80}, 2, 0);
    repeat (2) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ifa.out_vld !== 1'b0 || ifb.out_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b/%b expected 0/0", ifa.out_vld, ifb.out_vld); end
    n_checks++; if (ifa.out_data !== 8'd0) begin n_fail++; $display("FAIL arst_data: got %0d expected 0", ifa.out_data); end
    n_checks++; if (ifa.overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %b expected 0", ifa.overflow); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    clear_model();
    run_stream({0, 16, 32}, 2, 1);
    drain();
    n_checks++; if (gotA.size() != 2 || gotA[0] != 1 || gotA[1] != 2) begin n_fail++; $display("FAIL arst_reprime: got %0d outputs first %0d expected 2 outputs 1,2", gotA.size(), (gotA.size() > 0) ? gotA[0] : -1); end
    n_checks++; if (gotB.size() != 1 || gotB[0] != 2) begin n_fail++; $display("FAIL arst_pool_clear: got %0d outputs first %0d expected 1 output 2", gotB.size(), (gotB.size() > 0) ? gotB[0] : -1); end
  endtask

  initial begin
    ifa.new_sum = 1'b0;
    ifa.sum_in  = '0;
    ifa.out_rdy = 1'b0;
    set_bias(0);
    test_reset();
    test_priming();
    test_relu_sat();
    test_bias_round();
    test_pooling();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
